// File: rtl/modular_exp_async.sv
// Modular exponentiation engine: result = base^exp_in mod prime.
// Right-to-left square-and-multiply around a bit-serial modular multiplier.
module modular_exp_async (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [99:0]  base,
  input  logic [100:0] exp_in,
  input  logic [99:0]  prime,
  output logic [99:0]  result,
  output logic         dirty0,
  output logic         dirty1,
  output logic         div_ready_out
);

  localparam int unsigned OpW  = 100;
  localparam int unsigned ExpW = 101;
  localparam int unsigned AccW = 102;
  localparam int unsigned CntW = 7;
  localparam logic [CntW-1:0] LastIter = CntW'(OpW - 1);

  typedef enum logic [2:0] {S_IDLE, S_REDUCE, S_LOOP, S_MUL, S_SQR, S_DONE} state_e;
  typedef enum logic [1:0] {D_IDLE, D_LOAD, D_ITER, D_WB} dstate_e;

  // Control datapath
  state_e            state_q, state_d;
  logic [OpW-1:0]    base_q, base_d;
  logic [OpW-1:0]    p_q, p_d;
  logic [ExpW-1:0]   e_q, e_d;
  logic [OpW-1:0]    b_q, b_d;
  logic [OpW-1:0]    r_q, r_d;
  logic [OpW-1:0]    result_q, result_d;
  logic              dirty0_q, dirty0_d;
  logic              dirty1_q, dirty1_d;
  logic              go_c;

  // Multiplier datapath
  dstate_e           dstate_q, dstate_d;
  logic [OpW-1:0]    acc_q, acc_d;
  logic [OpW-1:0]    a_q, a_d;
  logic [OpW-1:0]    sh_q, sh_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              red_q, red_d;
  logic              ready_q, ready_d;
  logic              div_done_c;
  logic [OpW-1:0]    op_a_c, op_m_c;
  logic              op_red_c;
  logic [AccW-1:0]   p_ext_c, t1_c, t1r_c, t2_c;
  logic [OpW-1:0]    step_c;

  assign result        = result_q;
  assign dirty0        = dirty0_q;
  assign dirty1        = dirty1_q;
  assign div_ready_out = ready_q;
  assign div_done_c    = (dstate_q == D_WB);

  // Exponentiation sequencer: next state, operand latch, r/b/e updates.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    p_d      = p_q;
    e_d      = e_q;
    b_d      = b_q;
    r_d      = r_q;
    result_d = result_q;
    dirty0_d = dirty0_q;
    dirty1_d = dirty1_q;
    go_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d   = base;
          e_d      = exp_in;
          p_d      = prime;
          r_d      = OpW'(1);
          dirty0_d = 1'b1;
          dirty1_d = 1'b0;
          if (prime <= OpW'(1)) begin
            r_d     = '0;
            state_d = S_DONE;
          end else begin
            go_c    = 1'b1;
            state_d = S_REDUCE;
          end
        end
      end
      S_REDUCE: begin
        if (div_done_c) begin
          b_d     = acc_q;
          state_d = S_LOOP;
        end
      end
      S_LOOP: begin
        if (e_q == '0) begin
          state_d = S_DONE;
        end else begin
          go_c    = 1'b1;
          state_d = e_q[0] ? S_MUL : S_SQR;
        end
      end
      S_MUL: begin
        if (div_done_c) begin
          r_d = acc_q;
          // Last exponent bit: the square would be discarded, so skip it entirely.
          if (e_q[ExpW-1:1] == '0) begin
            e_d     = e_q >> 1;
            state_d = S_LOOP;
          end else begin
            go_c    = 1'b1;
            state_d = S_SQR;
          end
        end
      end
      S_SQR: begin
        if (div_done_c) begin
          b_d     = acc_q;
          e_d     = e_q >> 1;
          state_d = S_LOOP;
        end
      end
      S_DONE: begin
        result_d = r_q;
        dirty0_d = 1'b0;
        dirty1_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Multiplier operand selection, sampled during the multiplier load cycle.
  always_comb begin
    op_a_c   = b_q;
    op_m_c   = b_q;
    op_red_c = 1'b0;
    case (state_q)
      S_REDUCE: begin
        op_a_c   = base_q;
        op_m_c   = '0;
        op_red_c = 1'b1;
      end
      S_MUL: begin
        op_a_c = r_q;
        op_m_c = b_q;
      end
      default: ;
    endcase
  end

  // One MSB-first step: multiply mode adds a on set bits; reduce mode is
  // bit-serial long division of the raw base (same remainder as subtracting p*2^k).
  always_comb begin
    p_ext_c = AccW'(p_q);
    t1_c    = {1'b0, acc_q, 1'b0} + AccW'(red_q & sh_q[OpW-1]);
    t1r_c   = (t1_c >= p_ext_c) ? (t1_c - p_ext_c) : t1_c;
    t2_c    = t1r_c + ((!red_q && sh_q[OpW-1]) ? AccW'(a_q) : '0);
    step_c  = (t2_c >= p_ext_c) ? OpW'(t2_c - p_ext_c) : OpW'(t2_c);
  end

  // Multiplier sequencer: load, 100 iterations, writeback.
  always_comb begin
    dstate_d = dstate_q;
    acc_d    = acc_q;
    a_d      = a_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    red_d    = red_q;
    case (dstate_q)
      D_IDLE: if (go_c) dstate_d = D_LOAD;
      D_LOAD: begin
        acc_d    = '0;
        a_d      = op_a_c;
        sh_d     = op_red_c ? op_a_c : op_m_c;
        red_d    = op_red_c;
        cnt_d    = '0;
        dstate_d = D_ITER;
      end
      D_ITER: begin
        acc_d = step_c;
        sh_d  = {sh_q[OpW-2:0], 1'b0};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastIter) dstate_d = D_WB;
      end
      D_WB: dstate_d = go_c ? D_LOAD : D_IDLE;
      default: dstate_d = D_IDLE;
    endcase
    ready_d = (dstate_d == D_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      p_q      <= '0;
      e_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      result_q <= '0;
      dirty0_q <= 1'b0;
      dirty1_q <= 1'b0;
      dstate_q <= D_IDLE;
      acc_q    <= '0;
      a_q      <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      red_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      p_q      <= p_d;
      e_q      <= e_d;
      b_q      <= b_d;
      r_q      <= r_d;
      result_q <= result_d;
      dirty0_q <= dirty0_d;
      dirty1_q <= dirty1_d;
      dstate_q <= dstate_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      red_q    <= red_d;
      ready_q  <= ready_d;
    end
  end

endmodule

// File: tb/tb_modular_exp_async.sv
// Directed bench for modular_exp_async: results, latencies, status flags, reset.
module tb_modular_exp_async;

  logic         clk;
  logic         rst;
  logic         start;
  logic [99:0]  base;
  logic [100:0] exp_in;
  logic [99:0]  prime;
  logic [99:0]  result;
  logic         dirty0;
  logic         dirty1;
  logic         div_ready_out;

  int n_cmp;
  int n_bad;

  modular_exp_async dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base          (base),
    .exp_in        (exp_in),
    .prime         (prime),
    .result        (result),
    .dirty0        (dirty0),
    .dirty1        (dirty1),
    .div_ready_out (div_ready_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns 1 time unit after the sampling edge.
  task automatic do_start(input logic [99:0] b, input logic [100:0] e, input logic [99:0] p);
    @(negedge clk);
    base   = b;
    exp_in = e;
    prime  = p;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Edges from the start edge until dirty1 is seen high; -1 on timeout.
  task automatic wait_valid(input int budget, output int lat);
    lat = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      #1;
      if (dirty1 === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    logic [100:0] fer_e;
    logic [99:0]  fer_p;
    n_cmp  = 0;
    n_bad  = 0;
    clk    = 1'b0;
    rst    = 1'b1;
    start  = 1'b0;
    base   = '0;
    exp_in = '0;
    prime  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", 128'(result), 128'd0);
    check("rst_dirty0", 128'(dirty0), 128'd0);
    check("rst_dirty1", 128'(dirty1), 128'd0);
    check("rst_ready", 128'(div_ready_out), 128'd1);
    @(negedge clk);
    rst = 1'b0;

    // 5^23 mod 23, with operand changes and an ignored second start
    do_start(100'd5, 101'd23, 100'd23);
    check("t1_dirty0_set", 128'(dirty0), 128'd1);
    check("t1_dirty1_clr", 128'(dirty1), 128'd0);
    check("t1_ready_low", 128'(div_ready_out), 128'd0);
    lat = -1;
    for (int n = 1; n <= 1100; n++) begin
      if (n == 1) begin
        base   = 100'd7;
        exp_in = 101'd3;
        prime  = 100'd11;
      end
      if (n == 31) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (n == 32) begin
        check("t1_busy_after_2nd", 128'(dirty0), 128'd1);
        check("t1_no_valid_early", 128'(dirty1), 128'd0);
      end
      if (dirty1 === 1'b1) begin
        lat = n;
        break;
      end
    end
    check("t1_latency", 128'(lat), 128'd925);
    check("t1_result", 128'(result), 128'd5);
    check("t1_dirty0_clr", 128'(dirty0), 128'd0);
    check("t1_ready_idle", 128'(div_ready_out), 128'd1);
    repeat (5) @(posedge clk);
    #1;
    check("t1_hold_valid", 128'(dirty1), 128'd1);
    check("t1_hold_result", 128'(result), 128'd5);

    // base >= prime: 30^2 mod 23
    do_start(100'd30, 101'd2, 100'd23);
    check("t2_dirty1_clr", 128'(dirty1), 128'd0);
    check("t2_result_held", 128'(result), 128'd5);
    wait_valid(2000, lat);
    check("t2_latency", 128'(lat), 128'd310);
    check("t2_result", 128'(result), 128'd3);

    // Zero exponent
    do_start(100'd3, 101'd0, 100'd7);
    wait_valid(2000, lat);
    check("t3_latency", 128'(lat), 128'd104);
    check("t3_result", 128'(result), 128'd1);

    // Degenerate moduli
    do_start(100'd3, 101'd0, 100'd1);
    wait_valid(200, lat);
    check("t4_latency", 128'(lat), 128'd1);
    check("t4_result", 128'(result), 128'd0);
    check("t4_dirty0", 128'(dirty0), 128'd0);
    do_start(100'd2, 101'd10, 100'd1000003);
    wait_valid(2000, lat);
    check("t5_latency", 128'(lat), 128'd618);
    check("t5_result", 128'(result), 128'd1024);
    do_start(100'd9, 101'd5, 100'd0);
    wait_valid(200, lat);
    check("t6_latency", 128'(lat), 128'd1);
    check("t6_result", 128'(result), 128'd0);

    // Fermat on the Mersenne prime 2^89-1
    fer_e = (101'd1 << 89) - 101'd2;
    fer_p = (100'd1 << 89) - 100'd1;
    do_start(100'd2, fer_e, fer_p);
    wait_valid(20000, lat);
    check("t7_latency", 128'(lat), 128'd18145);
    check("t7_result", 128'(result), 128'd1);

    // Asynchronous reset in the middle of a computation
    do_start(100'd5, 101'd23, 100'd23);
    repeat (200) @(posedge clk);
    #2;
    check("t8_busy_before", 128'(dirty0), 128'd1);
    rst = 1'b1;
    #1;
    check("t8_rst_result", 128'(result), 128'd0);
    check("t8_rst_dirty0", 128'(dirty0), 128'd0);
    check("t8_rst_dirty1", 128'(dirty1), 128'd0);
    check("t8_rst_ready", 128'(div_ready_out), 128'd1);
    @(negedge clk);
    rst = 1'b0;
    do_start(100'd30, 101'd2, 100'd23);
    wait_valid(2000, lat);
    check("t8_latency", 128'(lat), 128'd310);
    check("t8_result", 128'(result), 128'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
